// File: rtl/id_scoreboard.sv
// id_scoreboard: register-hazard scoreboard and stall controller for decode.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   id_valid_i, flush_i             decode slot valid / killed this cycle
//   reg1_re_i/raddr_i, reg2_*       source register reads
//   reg_we_i, reg_waddr_i           destination write
//   id_long_i                       long-latency op (deferred writeback)
//   wb_valid_i, wb_waddr_i          long-op writeback retiring
//   stall_o, hazard_o               combinational stall and {struct, waw, raw} cause
//   busy_o, outstanding_o           pending-write bits and in-flight count
//   err_o, stall_cnt_o              sticky bad-retire flag, saturating stall cycles
module id_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic             reg1_re_i,
    input  logic [4:0]       reg1_raddr_i,
    input  logic             reg2_re_i,
    input  logic [4:0]       reg2_raddr_i,
    input  logic             reg_we_i,
    input  logic [4:0]       reg_waddr_i,
    input  logic             id_long_i,
    input  logic             flush_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_waddr_i,
    output logic             stall_o,
    output logic [2:0]       hazard_o,
    output logic [31:0]      busy_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o,
    output logic [31:0]      stall_cnt_o
);
    typedef enum logic {RUN, STALL} state_t;
    state_t state_q, state_d;
    logic [31:0] busy_q, busy_d, eff_busy, wb_mask, rd_mask, stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic gate, rd_nz, raw, waw, strc, stall, issue, retire;
    assign gate     = id_valid_i & ~flush_i;
    assign rd_nz    = reg_waddr_i != 5'd0;
    assign wb_mask  = wb_valid_i ? (32'd1 << wb_waddr_i) : 32'd0;
    // A retiring writeback hides its register from hazard checks in the same cycle
    assign eff_busy = busy_q & ~((WB_BYPASS != 0) ? wb_mask : 32'd0);
    assign retire   = wb_valid_i & busy_q[wb_waddr_i];
    assign raw      = (reg1_re_i & (reg1_raddr_i != 5'd0) & eff_busy[reg1_raddr_i])
                    | (reg2_re_i & (reg2_raddr_i != 5'd0) & eff_busy[reg2_raddr_i]);
    assign waw      = reg_we_i & rd_nz & eff_busy[reg_waddr_i];
    // A full table still accepts a new long op if a slot frees this cycle
    assign strc     = id_long_i & reg_we_i & rd_nz
                    & (cnt_q == CNT_W'(MAX_OUTSTANDING)) & ~retire;
    assign stall    = gate & (raw | waw | strc);
    assign issue    = gate & ~stall & id_long_i & reg_we_i & rd_nz;
    assign rd_mask  = issue ? (32'd1 << reg_waddr_i) : 32'd0;
    // Set after clear so issue wins over a same-register retire
    assign busy_d   = (busy_q & ~(retire ? wb_mask : 32'd0)) | rd_mask;
    assign cnt_d    = cnt_q + CNT_W'(issue) - CNT_W'(retire);
    assign err_d    = err_q | (wb_valid_i & ~busy_q[wb_waddr_i]);
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = stall ? STALL : RUN;
            STALL:   state_d = stall ? STALL : RUN;
            default: state_d = RUN;
        endcase
    end
    assign stall_cnt_d = (state_d == STALL && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            busy_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign stall_o       = stall;
    assign hazard_o      = gate ? {strc, waw, raw} : 3'b000;
    assign busy_o        = busy_q;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;
    assign stall_cnt_o   = stall_cnt_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed stimulus with queued expectations checked by a monitor.
module tb_id_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid_i, reg1_re_i, reg2_re_i, reg_we_i, id_long_i, flush_i, wb_valid_i;
    logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, wb_waddr_i;
    logic        stall_o, err_o;
    logic [2:0]  hazard_o, outstanding_o;
    logic [31:0] busy_o, stall_cnt_o;
    int total = 0;
    int bad = 0;
    typedef struct {
        string       name;
        logic        stall;
        logic [2:0]  haz;
        logic [31:0] busy;
        logic [2:0]  outst;
        logic        err;
        logic [31:0] scnt;
    } exp_t;
    exp_t q[$];
    id_scoreboard #(.MAX_OUTSTANDING(4), .WB_BYPASS(1), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i),
        .reg1_re_i(reg1_re_i), .reg1_raddr_i(reg1_raddr_i),
        .reg2_re_i(reg2_re_i), .reg2_raddr_i(reg2_raddr_i),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
        .id_long_i(id_long_i), .flush_i(flush_i),
        .wb_valid_i(wb_valid_i), .wb_waddr_i(wb_waddr_i),
        .stall_o(stall_o), .hazard_o(hazard_o), .busy_o(busy_o),
        .outstanding_o(outstanding_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", n, f, act, ex);
        end
    endtask
    // Monitor: every falling edge with a pending expectation compares all outputs
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "stall", 32'(stall_o), 32'(e.stall));
            chk(e.name, "hazard", 32'(hazard_o), 32'(e.haz));
            chk(e.name, "busy", busy_o, e.busy);
            chk(e.name, "outstanding", 32'(outstanding_o), 32'(e.outst));
            chk(e.name, "err", 32'(err_o), 32'(e.err));
            chk(e.name, "stall_cnt", stall_cnt_o, e.scnt);
        end
    end
    // Drive one cycle of inputs just after the rising edge
    task automatic drv(input logic v, input logic r1, input logic [4:0] a1, input logic r2,
                       input logic [4:0] a2, input logic we, input logic [4:0] wa, input logic lg,
                       input logic fl, input logic wv, input logic [4:0] wba);
        @(posedge clk);
        #1;
        id_valid_i = v; reg1_re_i = r1; reg1_raddr_i = a1; reg2_re_i = r2; reg2_raddr_i = a2;
        reg_we_i = we; reg_waddr_i = wa; id_long_i = lg; flush_i = fl;
        wb_valid_i = wv; wb_waddr_i = wba;
    endtask
    task automatic ex(input string n, input logic s, input logic [2:0] h, input logic [31:0] b,
                      input logic [2:0] o, input logic e, input logic [31:0] c);
        exp_t t;
        t.name = n; t.stall = s; t.haz = h; t.busy = b; t.outst = o; t.err = e; t.scnt = c;
        q.push_back(t);
    endtask
    task automatic idle(input string n, input logic [31:0] b, input logic [2:0] o, input logic e, input logic [31:0] c);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex(n, 0, 3'b000, b, o, e, c);
    endtask
    task automatic long_op(input string n, input logic [4:0] rd, input logic [31:0] b, input logic [2:0] o);
        drv(1, 0, 0, 0, 0, 1, rd, 1, 0, 0, 0);
        ex(n, 0, 3'b000, b, o, 0, 1);
    endtask
    task automatic retire(input string n, input logic [4:0] r, input logic [31:0] b, input logic [2:0] o);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
        ex(n, 0, 3'b000, b, o, 0, 2);
    endtask
    initial begin
        {id_valid_i, reg1_re_i, reg2_re_i, reg_we_i, id_long_i, flush_i, wb_valid_i} = '0;
        {reg1_raddr_i, reg2_raddr_i, reg_waddr_i, wb_waddr_i} = '0;
        idle("in_reset", 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        ex("reset_release", 0, 3'b000, 0, 0, 0, 0);
        // Load x5 then dependent add stalls until the writeback bypasses it
        drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        ex("load_x5", 0, 3'b000, 0, 0, 0, 0);
        drv(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        ex("raw_x5", 1, 3'b001, 32'h20, 1, 0, 0);
        drv(1, 1, 5, 0, 0, 1, 6, 0, 0, 1, 5);
        ex("raw_bypass", 0, 3'b000, 32'h20, 1, 0, 1);
        idle("x5_cleared", 0, 0, 0, 1);
        // Fill the table, fifth long op blocks until a slot retires alongside it
        long_op("long_x1", 1, 0, 0);
        long_op("long_x2", 2, 32'h02, 1);
        long_op("long_x3", 3, 32'h06, 2);
        long_op("long_x4", 4, 32'h0E, 3);
        drv(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
        ex("struct_full", 1, 3'b100, 32'h1E, 4, 0, 1);
        drv(1, 0, 0, 0, 0, 1, 6, 1, 0, 1, 1);
        ex("struct_retire", 0, 3'b000, 32'h1E, 4, 0, 2);
        retire("ret_x2", 2, 32'h5C, 4);
        retire("ret_x3", 3, 32'h58, 3);
        retire("ret_x4", 4, 32'h50, 2);
        retire("ret_x6", 6, 32'h40, 1);
        // Long op to x0 is ignored and x0 reads never stall
        drv(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        ex("long_x0", 0, 3'b000, 0, 0, 0, 2);
        idle("x0_untracked", 0, 0, 0, 2);
        // Same-cycle issue and retire of x7 keeps it busy
        drv(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        ex("long_x7", 0, 3'b000, 0, 0, 0, 2);
        drv(1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 7);
        ex("x7_reissue", 0, 3'b000, 32'h80, 1, 0, 2);
        idle("x7_still_busy", 32'h80, 1, 0, 2);
        // Retire to a non-busy register flags an error only
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        ex("bad_retire", 0, 3'b000, 32'h80, 1, 0, 2);
        idle("err_sticky", 32'h80, 1, 1, 2);
        // Flush masks the hazard and prevents issue
        drv(1, 1, 7, 0, 0, 1, 8, 1, 1, 0, 0);
        ex("flush", 0, 3'b000, 32'h80, 1, 1, 2);
        idle("flush_no_issue", 32'h80, 1, 1, 2);
        // Three stalled cycles: waw then raw on rs1 then raw on rs2
        drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        ex("waw_x7", 1, 3'b010, 32'h80, 1, 1, 2);
        drv(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        ex("raw_rs1", 1, 3'b001, 32'h80, 1, 1, 3);
        drv(1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        ex("raw_rs2", 1, 3'b001, 32'h80, 1, 1, 4);
        // Reset mid-stall clears everything before the next rising edge
        drv(1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        ex("async_reset", 0, 3'b000, 0, 0, 0, 0);
        idle("held_reset", 0, 0, 0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
